// File: rtl/serial_pkg.sv
// Shared definitions for the word serializer and its consumer-side deserializer.
//   state_e      : controller state encoding (idle, shifting data bits, parity beat)
//   WORD_W       : default word width (mux input count)
//   WORD_SEL_W   : default select width, clog2(WORD_W)
//   idx_bounds() : first and final bit index for a given bit order
package serial_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned WORD_SEL_W = 5;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StShift  = 2'd1,
      StParity = 2'd2
   } state_e;

   typedef struct packed {
      int unsigned start_idx;
      int unsigned final_idx;
   } idx_bounds_t;

   // LSB-first walks 0 -> width-1, MSB-first walks width-1 -> 0.
   function automatic idx_bounds_t idx_bounds(input bit msb_first, input int unsigned width);
      idx_bounds_t b;
      if (msb_first) begin
         b.start_idx = width - 1;
         b.final_idx = 0;
      end else begin
         b.start_idx = 0;
         b.final_idx = width - 1;
      end
      return b;
   endfunction

endpackage

// File: rtl/word_serializer_ctrl_if.sv
// Bus bundle between the word serializer controller and its surroundings.
//   upstream  : in_valid, in_ready, in_data
//   mux side  : mux_i (held word), mux_sel (bit index), mux_en (mux enable)
//   serial    : out_valid, out_ready, out_last, out_par, par_bit
//   status    : busy
// Modports: master = the controller, slave = upstream/mux/consumer environment.
interface word_serializer_ctrl_if #(
   parameter int unsigned WIDTH = serial_pkg::WORD_W,
   parameter int unsigned SEL_W = serial_pkg::WORD_SEL_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] mux_i;
   logic [SEL_W-1:0] mux_sel;
   logic             mux_en;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             out_par;
   logic             par_bit;
   logic             busy;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, mux_i, mux_sel, mux_en, out_valid, out_last, out_par, par_bit, busy
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, mux_i, mux_sel, mux_en, out_valid, out_last, out_par, par_bit, busy
   );

endinterface

// File: rtl/bit_index_counter.sv
// Up/down bit index counter with load, enable and final-index detection.
// Shared by the serializer controller and the consumer-side deserializer.
//   clk, rst_n : clock, synchronous active-low reset (count returns to 0)
//   load       : load load_val (takes priority over en)
//   load_val   : value loaded on load
//   en         : step one position toward final_val
//   up         : 1 = increment, 0 = decrement
//   final_val  : index at which counting stops
//   cnt        : current index
//   is_final   : cnt equals final_val
module bit_index_counter #(
   parameter int unsigned SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SEL_W-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic [SEL_W-1:0] final_val,
   output logic [SEL_W-1:0] cnt,
   output logic             is_final
);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   assign is_final = (cnt_q == final_val);
   assign cnt      = cnt_q;

   // Never steps past final_val, so an out-of-range index cannot be produced.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && !is_final) begin
         cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/word_serializer_ctrl.sv
// Control stage in front of a 32-to-1 enabled bit mux. Accepts a word over valid/ready,
// holds it on the mux data inputs and walks the mux select over every bit, one bit per
// accepted beat, so the mux output forms a framed serial stream.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : word_serializer_ctrl_if.master (upstream handshake, mux drive, serial framing)
// Parameters: WIDTH (word width = mux inputs), SEL_W (clog2(WIDTH)),
//             MSB_FIRST (0 = index 0 first, 1 = index WIDTH-1 first).
// Build option: define WORD_SERIALIZER_PARITY_EN to append an even-parity beat to each word.
module word_serializer_ctrl
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH     = WORD_W,
   parameter int unsigned SEL_W     = WORD_SEL_W,
   parameter bit          MSB_FIRST = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   word_serializer_ctrl_if.master bus
);

   localparam idx_bounds_t      Bounds   = idx_bounds(MSB_FIRST, WIDTH);
   localparam logic [SEL_W-1:0] StartIdx = SEL_W'(Bounds.start_idx);
   localparam logic [SEL_W-1:0] FinalIdx = SEL_W'(Bounds.final_idx);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             in_rdy;
   logic             accept;
   logic             cnt_en;
   logic             is_final;
   logic [SEL_W-1:0] sel;

   bit_index_counter #(
      .SEL_W (SEL_W)
   ) u_index (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .load_val  (StartIdx),
      .en        (cnt_en),
      .up        (~MSB_FIRST),
      .final_val (FinalIdx),
      .cnt       (sel),
      .is_final  (is_final)
   );

   // in_ready never looks at in_valid; on the closing beat it follows out_ready so the
   // next word loads on the same edge and SHIFT restarts without an idle cycle.
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         StIdle: begin
            in_rdy = 1'b1;
            if (bus.in_valid) state_d = StShift;
         end
         StShift: begin
            if (bus.out_ready) begin
               if (is_final) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                  state_d = StParity;
`else
                  in_rdy  = 1'b1;
                  state_d = bus.in_valid ? StShift : StIdle;
`endif
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
`ifdef WORD_SERIALIZER_PARITY_EN
         StParity: begin
            if (bus.out_ready) begin
               in_rdy  = 1'b1;
               state_d = bus.in_valid ? StShift : StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   assign accept = bus.in_valid & in_rdy;
   assign word_d = accept ? bus.in_data : word_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.mux_i     = word_q;
   assign bus.mux_sel   = sel;
   assign bus.mux_en    = (state_q == StShift);
   assign bus.out_valid = (state_q != StIdle);
   assign bus.busy      = (state_q != StIdle);

`ifdef WORD_SERIALIZER_PARITY_EN
   // Mux is disabled on the parity beat; the parity value travels on par_bit instead.
   assign bus.out_last = (state_q == StParity);
   assign bus.out_par  = (state_q == StParity);
   assign bus.par_bit  = (state_q == StParity) & (^word_q);
`else
   assign bus.out_last = (state_q == StShift) & is_final;
   assign bus.out_par  = 1'b0;
   assign bus.par_bit  = 1'b0;
`endif

endmodule

// File: tb/tb_word_serializer_ctrl.sv
module tb_word_serializer_ctrl;

   localparam int W = 32;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = W + PAR;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   word_serializer_ctrl_if #(.WIDTH(32), .SEL_W(5)) a ();
   word_serializer_ctrl_if #(.WIDTH(32), .SEL_W(5)) m ();

   word_serializer_ctrl #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1'b0)) u_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a)
   );

   word_serializer_ctrl #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1'b1)) u_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic accept_lsb(input logic [31:0] w);
      @(posedge clk);
      #1;
      a.in_valid = 1'b1;
      a.in_data  = w;
      @(negedge clk);
      check("acc_in_ready", 32'(a.in_ready), 32'd1);
      check("acc_busy", 32'(a.busy), 32'd0);
      @(posedge clk);
   endtask

   // Entered right at the acceptance edge; walks every beat of word w against the model.
   task automatic beats_lsb(input logic [31:0] w, input bit toggle, input bit hold_next,
                            input logic [31:0] nxt);
      int k = 0;
      int c = 0;
      bit rdy;
      #1;
      a.in_valid = hold_next;
      if (hold_next) a.in_data = nxt;
      while (k < NB && c < 4 * NB + 8) begin
         rdy = toggle ? c[0] : 1'b1;
         a.out_ready = rdy;
         @(negedge clk);
         check("sel", 32'(a.mux_sel), (k < W) ? k : W - 1);
         check("mux_en", 32'(a.mux_en), 32'(k < W));
         check("out_valid", 32'(a.out_valid), 32'd1);
         check("out_last", 32'(a.out_last), 32'((PAR == 1) ? (k == W) : (k == W - 1)));
         check("out_par", 32'(a.out_par), 32'(k == W));
         check("mux_i", a.mux_i, w);
         check("busy", 32'(a.busy), 32'd1);
         check("in_ready", 32'(a.in_ready), 32'(rdy && (k == NB - 1)));
         if (k < W) begin
            check("ybit", 32'(a.mux_i[a.mux_sel]), 32'(w[k]));
            check("par_bit_data", 32'(a.par_bit), 32'd0);
         end else begin
            check("par_bit", 32'(a.par_bit), 32'(^w));
         end
         @(posedge clk);
         #1;
         if (rdy) k++;
         c++;
      end
      check("beats", k, NB);
      check("cycles", c, toggle ? 2 * NB : NB);
      if (!hold_next) begin
         a.out_ready = 1'b1;
         @(negedge clk);
         check("end_busy", 32'(a.busy), 32'd0);
         check("end_in_ready", 32'(a.in_ready), 32'd1);
         check("end_mux_en", 32'(a.mux_en), 32'd0);
         check("end_out_valid", 32'(a.out_valid), 32'd0);
         check("end_out_last", 32'(a.out_last), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] mw;
      a.in_valid  = 1'b0;
      a.in_data   = '0;
      a.out_ready = 1'b1;
      m.in_valid  = 1'b0;
      m.in_data   = '0;
      m.out_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(a.in_ready), 32'd1);
      check("rst_busy", 32'(a.busy), 32'd0);
      check("rst_mux_i", a.mux_i, 32'd0);
      check("rst_mux_sel", 32'(a.mux_sel), 32'd0);
      check("rst_mux_en", 32'(a.mux_en), 32'd0);
      check("rst_out_valid", 32'(a.out_valid), 32'd0);
      check("rst_out_last", 32'(a.out_last), 32'd0);
      check("rst_out_par", 32'(a.out_par), 32'd0);
      check("rst_par_bit", 32'(a.par_bit), 32'd0);
      check("rst_msb_sel", 32'(m.mux_sel), 32'd0);
      check("rst_msb_in_ready", 32'(m.in_ready), 32'd1);

      // Free-running word, then the same word under 1/0 backpressure
      accept_lsb(32'hA5A5_0001);
      beats_lsb(32'hA5A5_0001, 1'b0, 1'b0, 32'h0);
      accept_lsb(32'hA5A5_0001);
      beats_lsb(32'hA5A5_0001, 1'b1, 1'b0, 32'h0);

      // Back-to-back words, in_valid held high through the first word
      accept_lsb(32'hFFFF_FFFF);
      beats_lsb(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000);
      beats_lsb(32'h0000_0000, 1'b0, 1'b0, 32'h0);

      // MSB-first instance
      mw = 32'h8000_0000;
      @(posedge clk);
      #1;
      m.in_valid = 1'b1;
      m.in_data  = mw;
      @(posedge clk);
      #1 m.in_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
         @(negedge clk);
         check("msb_sel", 32'(m.mux_sel), (k < W) ? (W - 1 - k) : 0);
         check("msb_last", 32'(m.out_last), 32'((PAR == 1) ? (k == W) : (k == W - 1)));
         if (k < W) check("msb_ybit", 32'(m.mux_i[m.mux_sel]), 32'(k == 0));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("msb_end_busy", 32'(m.busy), 32'd0);
      check("msb_end_in_ready", 32'(m.in_ready), 32'd1);

      // Reset while mid-word at index 10
      accept_lsb(32'h1234_5678);
      #1;
      a.in_valid  = 1'b0;
      a.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("pre_rst_sel", 32'(a.mux_sel), 32'd10);
      check("pre_rst_last", 32'(a.out_last), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_sel", 32'(a.mux_sel), 32'd0);
      check("mid_rst_mux_i", a.mux_i, 32'd0);
      check("mid_rst_mux_en", 32'(a.mux_en), 32'd0);
      check("mid_rst_out_valid", 32'(a.out_valid), 32'd0);
      check("mid_rst_out_par", 32'(a.out_par), 32'd0);
      check("mid_rst_par_bit", 32'(a.par_bit), 32'd0);
      check("mid_rst_busy", 32'(a.busy), 32'd0);
      check("mid_rst_in_ready", 32'(a.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("mid_rst_no_last", 32'(a.out_last), 32'd0);
         @(negedge clk);
      end

      // Parity-beat word (odd parity of 3 ones)
      accept_lsb(32'h0000_0007);
      beats_lsb(32'h0000_0007, 1'b0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
